// File: rtl/counter_event_pkg.sv
// Shared definitions for the counter event monitor: flag bit positions,
// the flag vector type and the width of the dropped-record counter.
package counter_event_pkg;

  localparam int FLAG_WRAP  = 0;
  localparam int FLAG_CLEAR = 1;
  localparam int FLAG_MATCH = 2;
  localparam int FLAG_W     = 3;
  localparam int DROP_W     = 8;

  typedef logic [FLAG_W-1:0] event_flags_t;

endpackage

// File: rtl/event_fifo.sv
// Record FIFO with push/full on the write side and valid/ready on the read side.
// A push into a full FIFO is accepted only when the head is popped on the same edge.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int REC_W = 19,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push,
  input  logic [REC_W-1:0] push_data,
  output logic             full,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [REC_W-1:0] pop_data,
  output logic [AW:0]      level
);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             wr_en;

  assign full      = (level == (AW+1)'(DEPTH));
  assign pop_valid = (level != '0);
  assign pop       = pop_valid & pop_ready;
  assign wr_en     = push & (~full | pop);
  // Empty FIFO presents zeros so stale storage never leaks onto the outputs.
  assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/counter_event_monitor.sv
// Watches an upstream counter for wrap, clear and compare-match events and
// queues one {flags, count} record per event cycle, tracking dropped records.
module counter_event_monitor
  import counter_event_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [WIDTH-1:0]       count,
  input  logic [WIDTH-1:0]       cmp_val,
  input  logic                   clr_stat,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [FLAG_W-1:0]      ev_flags,
  output logic [WIDTH-1:0]       ev_stamp,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  typedef struct packed {
    event_flags_t     flags;
    logic [WIDTH-1:0] stamp;
  } event_rec_t;

  logic [WIDTH-1:0] prev;
  logic             prev_valid;
  event_flags_t     flags;
  event_rec_t       rec_in;
  event_rec_t       rec_out;
  logic             push;
  logic             full;
  logic             drop;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev       <= count;
      prev_valid <= 1'b1;
    end
  end

  // The first sample after reset has no meaningful predecessor, so it never raises an event.
  always_comb begin
    flags = '0;
    if (prev_valid) begin
      flags[FLAG_WRAP]  = (prev == '1) && (count == '0);
      flags[FLAG_CLEAR] = (count == '0) && (prev != '0) && (prev != '1);
      flags[FLAG_MATCH] = (count == cmp_val) && (count != prev);
    end
  end

  assign push   = |flags;
  assign rec_in = '{flags: flags, stamp: count};
  assign drop   = push & full & ~(ev_valid & ev_ready);

  event_fifo #(
    .DEPTH (DEPTH),
    .REC_W ($bits(event_rec_t))
  ) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (push),
    .push_data (rec_in),
    .full      (full),
    .pop_valid (ev_valid),
    .pop_ready (ev_ready),
    .pop_data  (rec_out),
    .level     (level)
  );

  assign ev_flags = rec_out.flags;
  assign ev_stamp = rec_out.stamp;

  // A drop wins over clr_stat so the cycle's loss is still recorded after the clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_stat)
        drop_cnt <= DROP_W'(1);
      else if (drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_W'(1);
    end else if (clr_stat) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_counter_event_monitor.sv
// Directed bench for counter_event_monitor: a queue-based reference model is
// checked every cycle, with literal expectations pinning each scenario.
module tb_counter_event_monitor;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             nreset;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] cmp_val;
  logic             clr_stat;
  logic             ev_ready;
  logic             ev_valid;
  logic [2:0]       ev_flags;
  logic [WIDTH-1:0] ev_stamp;
  logic             overflow;
  logic [7:0]       drop_cnt;
  logic [LW-1:0]    level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_event_monitor #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .count    (count),
    .cmp_val  (cmp_val),
    .clr_stat (clr_stat),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_flags (ev_flags),
    .ev_stamp (ev_stamp),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .level    (level)
  );

  typedef struct {
    logic [2:0]       flags;
    logic [WIDTH-1:0] stamp;
  } rec_t;

  rec_t             mq[$];
  logic [WIDTH-1:0] m_prev = '0;
  bit               m_pv   = 1'b0;
  bit               m_ovf  = 1'b0;
  int               m_drop = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] cv,
                               input logic rdy, input logic clr);
    count    = c;
    cmp_val  = cv;
    ev_ready = rdy;
    clr_stat = clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: event rules applied to the sampled inputs, records kept in a queue.
  always @(posedge clk or negedge nreset) begin
    logic [2:0] f;
    bit         popping;
    bit         was_full;
    bit         dropped;
    rec_t       r;
    if (!nreset) begin
      mq.delete();
      m_prev = '0;
      m_pv   = 1'b0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      f = 3'b000;
      if (m_pv) begin
        if (m_prev == 16'hFFFF && count == 16'h0000) f[0] = 1'b1;
        if (count == 16'h0000 && m_prev != 16'h0000 && m_prev != 16'hFFFF) f[1] = 1'b1;
        if (count == cmp_val && count != m_prev) f[2] = 1'b1;
      end
      popping  = (mq.size() > 0) && ev_ready;
      was_full = (mq.size() == DEPTH);
      dropped  = 1'b0;
      if (popping) void'(mq.pop_front());
      if (f != 3'b000) begin
        if (!was_full || popping) begin
          r.flags = f;
          r.stamp = count;
          mq.push_back(r);
        end else begin
          dropped = 1'b1;
        end
      end
      if (dropped) begin
        m_ovf  = 1'b1;
        m_drop = clr_stat ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (clr_stat) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      m_prev = count;
      m_pv   = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit exp_valid;
    exp_valid = (mq.size() > 0);
    checkOutput("model ev_valid", {31'b0, ev_valid}, {31'b0, exp_valid});
    checkOutput("model ev_flags", {29'b0, ev_flags}, exp_valid ? {29'b0, mq[0].flags} : 32'h0);
    checkOutput("model ev_stamp", {16'b0, ev_stamp}, exp_valid ? {16'b0, mq[0].stamp} : 32'h0);
    checkOutput("model level", {29'b0, level}, mq.size());
    checkOutput("model overflow", {31'b0, overflow}, {31'b0, m_ovf});
    checkOutput("model drop_cnt", {24'b0, drop_cnt}, m_drop);
  end

  initial begin
    nreset   = 1'b0;
    count    = '0;
    cmp_val  = 16'h1234;
    clr_stat = 1'b0;
    ev_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset ev_valid", {31'b0, ev_valid}, 32'd0);
    checkOutput("reset level", {29'b0, level}, 32'd0);
    checkOutput("reset overflow", {31'b0, overflow}, 32'd0);
    checkOutput("reset drop_cnt", {24'b0, drop_cnt}, 32'd0);
    checkOutput("reset ev_stamp", {16'b0, ev_stamp}, 32'd0);
    checkOutput("reset ev_flags", {29'b0, ev_flags}, 32'd0);
    nreset = 1'b1;

    // Wrap 0xFFFF -> 0x0000
    applyStimulus(16'hFFFE, 16'h1234, 1'b1, 1'b0);
    applyStimulus(16'hFFFF, 16'h1234, 1'b1, 1'b0);
    applyStimulus(16'h0000, 16'h1234, 1'b1, 1'b0);
    checkOutput("wrap valid", {31'b0, ev_valid}, 32'd1);
    checkOutput("wrap flags", {29'b0, ev_flags}, 32'b001);
    checkOutput("wrap stamp", {16'b0, ev_stamp}, 32'h0000);
    checkOutput("wrap level", {29'b0, level}, 32'd1);
    applyStimulus(16'h0000, 16'h1234, 1'b1, 1'b0);
    checkOutput("wrap drained", {29'b0, level}, 32'd0);

    // Held match triggers once
    applyStimulus(16'h0008, 16'h0010, 1'b0, 1'b0);
    repeat (5) applyStimulus(16'h0010, 16'h0010, 1'b0, 1'b0);
    checkOutput("match level", {29'b0, level}, 32'd1);
    checkOutput("match flags", {29'b0, ev_flags}, 32'b100);
    checkOutput("match stamp", {16'b0, ev_stamp}, 32'h0010);
    applyStimulus(16'h0010, 16'h0010, 1'b1, 1'b0);
    checkOutput("match drained", {29'b0, level}, 32'd0);

    // Upstream clear coincident with match at cmp_val 0
    applyStimulus(16'h0437, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
    checkOutput("clear flags", {29'b0, ev_flags}, 32'b110);
    checkOutput("clear stamp", {16'b0, ev_stamp}, 32'h0000);
    checkOutput("clear level", {29'b0, level}, 32'd1);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("clear drained", {29'b0, level}, 32'd0);

    // Six matches into a 4-deep FIFO, then drain in order
    for (int i = 0; i < 6; i++)
      applyStimulus(16'h0100 + 16'(i), 16'h0100 + 16'(i), 1'b0, 1'b0);
    checkOutput("ovf level", {29'b0, level}, 32'd4);
    checkOutput("ovf overflow", {31'b0, overflow}, 32'd1);
    checkOutput("ovf drop_cnt", {24'b0, drop_cnt}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain stamp", {16'b0, ev_stamp}, 32'h0100 + i);
      applyStimulus(16'h0105, 16'h0105, 1'b1, 1'b0);
    end
    checkOutput("drain level", {29'b0, level}, 32'd0);

    // Full with simultaneous push and pop, then stat clearing
    for (int i = 0; i < 4; i++)
      applyStimulus(16'h0200 + 16'(i), 16'h0200 + 16'(i), 1'b0, 1'b0);
    applyStimulus(16'h0204, 16'h0204, 1'b1, 1'b0);
    checkOutput("pushpop level", {29'b0, level}, 32'd4);
    checkOutput("pushpop drop_cnt", {24'b0, drop_cnt}, 32'd2);
    checkOutput("pushpop head", {16'b0, ev_stamp}, 32'h0201);
    applyStimulus(16'h0204, 16'h0204, 1'b0, 1'b1);
    checkOutput("clr overflow", {31'b0, overflow}, 32'd0);
    checkOutput("clr drop_cnt", {24'b0, drop_cnt}, 32'd0);
    applyStimulus(16'h0205, 16'h0205, 1'b0, 1'b1);
    checkOutput("clr+drop overflow", {31'b0, overflow}, 32'd1);
    checkOutput("clr+drop drop_cnt", {24'b0, drop_cnt}, 32'd1);
    applyStimulus(16'h0205, 16'h0205, 1'b0, 1'b1);

    // Drop counter saturation
    for (int i = 0; i < 260; i++)
      applyStimulus(16'h0300 + 16'(i), 16'h0300 + 16'(i), 1'b0, 1'b0);
    checkOutput("sat drop_cnt", {24'b0, drop_cnt}, 32'd255);
    checkOutput("sat overflow", {31'b0, overflow}, 32'd1);
    repeat (4) applyStimulus(16'h0403, 16'h0403, 1'b1, 1'b0);
    applyStimulus(16'h0403, 16'h0403, 1'b0, 1'b1);
    checkOutput("sat drained", {29'b0, level}, 32'd0);

    // Reset with queued records
    for (int i = 0; i < 3; i++)
      applyStimulus(16'h0500 + 16'(i), 16'h0500 + 16'(i), 1'b0, 1'b0);
    checkOutput("preq level", {29'b0, level}, 32'd3);
    #2 nreset = 1'b0;
    count   = 16'h0000;
    cmp_val = 16'h0000;
    #1;
    checkOutput("async valid", {31'b0, ev_valid}, 32'd0);
    checkOutput("async level", {29'b0, level}, 32'd0);
    checkOutput("async stamp", {16'b0, ev_stamp}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
    checkOutput("post-reset zero", {29'b0, level}, 32'd0);

    // First post-reset sample must not match even when it differs from prev
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    applyStimulus(16'h0050, 16'h0050, 1'b0, 1'b0);
    checkOutput("post-reset match", {29'b0, level}, 32'd0);
    applyStimulus(16'h0051, 16'h0051, 1'b0, 1'b0);
    checkOutput("after-reset level", {29'b0, level}, 32'd1);
    checkOutput("after-reset stamp", {16'b0, ev_stamp}, 32'h0051);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
